// File: rtl/switch_pkg.sv
// Shared types and constants for the AXI-Stream switch slices.
package switch_pkg;

  localparam int DROP_CNT_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_DEST_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } route_state_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_DEST_WIDTH-1:0] dest;
    logic                      last;
  } beat_t;

  // Saturating increment used by the drop counter.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] value);
    if (value == {DROP_CNT_WIDTH{1'b1}}) begin
      return value;
    end else begin
      return value + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: a registered output stage backed by one skid entry,
// so upstream ready never depends combinationally on downstream ready.
module axis_skid_buffer
  import switch_pkg::*;
#(
  parameter type beat_type = beat_t
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  beat_type in_beat,
  output logic     out_valid,
  input  logic     out_ready,
  output beat_type out_beat
);

  logic     out_valid_r;
  logic     out_valid_next_s;
  beat_type out_beat_r;
  beat_type out_beat_next_s;
  logic     skid_valid_r;
  logic     skid_valid_next_s;
  beat_type skid_beat_r;
  beat_type skid_beat_next_s;
  logic     ready_r;
  logic     in_fire_s;
  logic     out_free_s;

  assign in_fire_s  = in_valid && ready_r;
  assign out_free_s = !out_valid_r || out_ready;

  // Next-state of the output and skid entries; the skid entry always drains first to keep order.
  always_comb begin
    out_valid_next_s  = out_valid_r;
    out_beat_next_s   = out_beat_r;
    skid_valid_next_s = skid_valid_r;
    skid_beat_next_s  = skid_beat_r;
    if (out_free_s) begin
      if (skid_valid_r) begin
        out_valid_next_s  = 1'b1;
        out_beat_next_s   = skid_beat_r;
        skid_valid_next_s = in_fire_s;
        if (in_fire_s) begin
          skid_beat_next_s = in_beat;
        end else begin
          skid_beat_next_s = skid_beat_r;
        end
      end else if (in_fire_s) begin
        out_valid_next_s = 1'b1;
        out_beat_next_s  = in_beat;
      end else begin
        out_valid_next_s = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_valid_next_s = 1'b1;
      skid_beat_next_s  = in_beat;
    end else begin
      skid_valid_next_s = skid_valid_r;
    end
  end

  // State registers; ready is registered from the skid occupancy it will have next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_beat_r   <= '0;
      skid_valid_r <= 1'b0;
      skid_beat_r  <= '0;
      ready_r      <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_next_s;
      out_beat_r   <= out_beat_next_s;
      skid_valid_r <= skid_valid_next_s;
      skid_beat_r  <= skid_beat_next_s;
      ready_r      <= !skid_valid_next_s;
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = out_valid_r;
  assign out_beat  = out_beat_r;

endmodule

// File: rtl/demux_unit.sv
// Per-input routing stage: locks a tdest for each packet, drops packets with an
// out-of-range tdest, and presents beats one-hot on the selected master channel.
module demux_unit
  import switch_pkg::*;
#(
  parameter int M_DATA_COUNT = 10,
  parameter int T_DATA_WIDTH = 64,
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [T_DEST_WIDTH-1:0]   s_dest_i,
  input  logic                      s_last_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  output logic [T_DATA_WIDTH-1:0]   m_data_o,
  output logic [T_DEST_WIDTH-1:0]   m_dest_o,
  output logic                      m_last_o,
  output logic [M_DATA_COUNT-1:0]   m_valid_o,
  input  logic [M_DATA_COUNT-1:0]   m_ready_i,
  output logic                      drop_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_DEST_WIDTH-1:0] dest;
    logic                    last;
  } lane_beat_t;

  localparam logic [T_DEST_WIDTH:0] DEST_LIMIT = (T_DEST_WIDTH+1)'(M_DATA_COUNT);

  route_state_t              state_r;
  logic [T_DEST_WIDTH-1:0]   dest_r;
  logic                      drop_r;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;
  logic                      accept_s;
  logic                      dest_ok_s;
  logic                      push_valid_s;
  logic                      push_ready_s;
  logic                      out_valid_s;
  logic                      out_ready_s;
  lane_beat_t                push_beat_s;
  lane_beat_t                out_beat_s;
  logic [M_DATA_COUNT-1:0]   m_valid_s;

  assign accept_s  = s_valid_i && push_ready_s;
  assign dest_ok_s = ({1'b0, s_dest_i} < DEST_LIMIT);

  // First beats steer on their own tdest; later beats follow the dest latched for the packet.
  always_comb begin
    push_beat_s.data = s_data_i;
    push_beat_s.last = s_last_i;
    push_beat_s.dest = dest_r;
    push_valid_s     = 1'b0;
    case (state_r)
      IDLE: begin
        push_beat_s.dest = s_dest_i;
        push_valid_s     = s_valid_i && dest_ok_s;
      end
      PKT:     push_valid_s = s_valid_i;
      DROP:    push_valid_s = 1'b0;
      default: push_valid_s = 1'b0;
    endcase
  end

  // Packet routing FSM, drop pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      dest_r     <= '0;
      drop_r     <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      drop_r <= 1'b0;
      if (accept_s) begin
        case (state_r)
          IDLE: begin
            if (dest_ok_s) begin
              dest_r  <= s_dest_i;
              state_r <= s_last_i ? IDLE : PKT;
            end else begin
              drop_r     <= 1'b1;
              drop_cnt_r <= sat_inc(drop_cnt_r);
              state_r    <= s_last_i ? IDLE : DROP;
            end
          end
          PKT, DROP: begin
            if (s_last_i) begin
              state_r <= IDLE;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  axis_skid_buffer #(
    .beat_type (lane_beat_t)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (push_valid_s),
    .in_ready  (push_ready_s),
    .in_beat   (push_beat_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .out_beat  (out_beat_s)
  );

  // One-hot valid decode of the registered output dest.
  always_comb begin
    m_valid_s = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      if (out_valid_s && (out_beat_s.dest == T_DEST_WIDTH'(i))) begin
        m_valid_s[i] = 1'b1;
      end else begin
        m_valid_s[i] = 1'b0;
      end
    end
  end

  assign out_ready_s = |(m_valid_s & m_ready_i);
  assign s_ready_o   = push_ready_s;
  assign m_valid_o   = m_valid_s;
  assign m_data_o    = out_beat_s.data;
  assign m_dest_o    = out_beat_s.dest;
  assign m_last_o    = out_beat_s.last;
  assign drop_o      = drop_r;
  assign drop_cnt_o  = drop_cnt_r;

endmodule

// File: tb/tb_demux_unit.sv
// Bench for demux_unit: directed tables and sequences plus randomized packets
// checked against a packet-level reference model of the routing rules.
`timescale 1ns/1ps
module tb_demux_unit;

  localparam int M   = 10;
  localparam int DW  = 64;
  localparam int DEW = 4;
  localparam logic [M-1:0] ALL_READY = 10'h3FF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_data_i = '0;
  logic [DEW-1:0] s_dest_i = '0;
  logic          s_last_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic [DEW-1:0] m_dest_o;
  logic          m_last_o;
  logic [M-1:0]  m_valid_o;
  logic [M-1:0]  m_ready_i = ALL_READY;
  logic          drop_o;
  logic [15:0]   drop_cnt_o;

  always #5 clk = ~clk;

  demux_unit #(.M_DATA_COUNT(M), .T_DATA_WIDTH(DW), .T_DEST_WIDTH(DEW)) dut (
    .clk(clk), .reset(reset), .s_data_i(s_data_i), .s_dest_i(s_dest_i),
    .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_dest_o(m_dest_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .drop_o(drop_o),
    .drop_cnt_o(drop_cnt_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            dest;
    logic          last;
  } exp_beat_t;

  typedef struct {
    logic [DEW-1:0] dest;
    logic [DW-1:0]  data;
    logic [M-1:0]   exp_valid;
    logic [15:0]    exp_cnt;
  } vec_t;

  exp_beat_t   exp_q[$];
  vec_t        tbl[8];
  int          checks = 0;
  int          fails = 0;
  bit          in_pkt;
  bit          cur_drop;
  int          cur_dest;
  int          model_drops;
  logic [15:0] exp_cnt;
  int          mon_drops;
  bit          rnd_on;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] onehot(input int d);
    logic [M-1:0] v;
    v = '0;
    if (d >= 0 && d < M) v[d] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    in_pkt      = 1'b0;
    cur_drop    = 1'b0;
    cur_dest    = 0;
    model_drops = 0;
    exp_cnt     = 16'd0;
  endtask

  // Packet-level routing rules: dest chosen by the first beat, bad dest drops the packet.
  task automatic model_accept(input logic [DW-1:0] d, input int dest, input logic last);
    exp_beat_t e;
    if (!in_pkt) begin
      if (dest < M) begin
        cur_dest = dest;
        cur_drop = 1'b0;
      end else begin
        cur_drop = 1'b1;
        model_drops++;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
    if (!cur_drop) begin
      e.data = d; e.dest = cur_dest; e.last = last;
      exp_q.push_back(e);
    end
    in_pkt = !last;
  endtask

  task automatic put_beat(input logic [DW-1:0] d, input logic [DEW-1:0] de, input logic l);
    int guard = 0;
    s_valid_i = 1'b1; s_data_i = d; s_dest_i = de; s_last_i = l;
    while (!s_ready_o && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check("s_ready_wait", 64'(guard < 300), 64'd1);
    if (guard < 300) begin
      @(posedge clk); #1;
      model_accept(d, int'(de), l);
    end
    s_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output-side checker: one-hot, drop pulse/count, hold-while-stalled, in-order beats.
  task automatic monitor();
    logic [M-1:0]   pv = '0;
    logic [DW-1:0]  pd = '0;
    logic [DEW:0]   ptag = '0;
    bit             have_prev = 1'b0;
    bit             pdone = 1'b0;
    bit             done;
    exp_beat_t      e;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_prev = 1'b0;
        mon_drops = 0;
      end else begin
        check("onehot", 64'($countones(m_valid_o) <= 1), 64'd1);
        check("drop_pulse", 64'(drop_o), 64'(model_drops != mon_drops));
        mon_drops = model_drops;
        check("drop_cnt", 64'(drop_cnt_o), 64'(exp_cnt));
        if (have_prev && pv != '0 && !pdone) begin
          check("hold_valid", 64'(m_valid_o), 64'(pv));
          check("hold_data", m_data_o, pd);
          check("hold_tag", 64'({m_dest_o, m_last_o}), 64'(ptag));
        end
        done = ((m_valid_o & m_ready_i) != '0);
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(m_valid_o), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_valid", 64'(m_valid_o), 64'(onehot(e.dest)));
            check("out_data", m_data_o, e.data);
            check("out_dest", 64'(m_dest_o), 64'(e.dest));
            check("out_last", 64'(m_last_o), 64'(e.last));
          end
        end
        pv = m_valid_o; pd = m_data_o; ptag = {m_dest_o, m_last_o};
        pdone = done; have_prev = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int dest;
    tbl[0] = '{4'd0,  64'h0000_0000_0000_0A00, 10'b0000000001, 16'd1};
    tbl[1] = '{4'd5,  64'h0000_0000_0000_0A01, 10'b0000100000, 16'd1};
    tbl[2] = '{4'd9,  64'h0000_0000_0000_0A02, 10'b1000000000, 16'd1};
    tbl[3] = '{4'd10, 64'h0000_0000_0000_0A03, 10'b0000000000, 16'd2};
    tbl[4] = '{4'd3,  64'h0000_0000_0000_0A04, 10'b0000001000, 16'd2};
    tbl[5] = '{4'd12, 64'h0000_0000_0000_0A05, 10'b0000000000, 16'd3};
    tbl[6] = '{4'd15, 64'h0000_0000_0000_0A06, 10'b0000000000, 16'd4};
    tbl[7] = '{4'd7,  64'h0000_0000_0000_0A07, 10'b0010000000, 16'd4};

    model_reset();
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid_o), 64'd0);
    check("rst_s_ready", 64'(s_ready_o), 64'd0);
    check("rst_drop", 64'(drop_o), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("rst_data", m_data_o, 64'd0);
    check("rst_tag", 64'({m_dest_o, m_last_o}), 64'd0);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("ready_after_rst", 64'(s_ready_o), 64'd1);

    // 4-beat packet to channel 3
    for (int k = 0; k < 4; k++) begin
      put_beat(64'h1111_0000_0000_0000 + 64'(k), 4'd3, k == 3);
      check("p4_valid", 64'(m_valid_o), 64'(10'b0000001000));
      check("p4_data", m_data_o, 64'h1111_0000_0000_0000 + 64'(k));
      check("p4_last", 64'(m_last_o), 64'(k == 3));
    end
    idle(1);
    check("p4_idle", 64'(m_valid_o), 64'd0);

    // tdest changes mid-packet are ignored
    for (int k = 0; k < 4; k++) begin
      put_beat(64'h2222_0000_0000_0000 + 64'(k), (k == 0) ? 4'd2 : 4'd7, k == 3);
      check("lock_valid", 64'(m_valid_o), 64'(10'b0000000100));
    end
    idle(1);

    // Channel 5 stalls for three cycles mid-packet
    put_beat(64'h3333_0000_0000_0000, 4'd5, 1'b0);
    fork
      begin
        for (int k = 1; k < 6; k++) begin
          put_beat(64'h3333_0000_0000_0000 + 64'(k), 4'd5, k == 5);
        end
      end
      begin
        m_ready_i = ALL_READY & ~10'b0000100000;
        @(posedge clk); #1;
        check("stall_s_ready", 64'(s_ready_o), 64'd0);
        check("stall_hold", m_data_o, 64'h3333_0000_0000_0000);
        repeat (2) @(posedge clk);
        #1;
        m_ready_i = ALL_READY;
      end
    join
    drain();

    // Out-of-range dest packet is dropped, next packet routes normally
    put_beat(64'h4444_0000_0000_0000, 4'd12, 1'b0);
    check("drop_pulse_now", 64'(drop_o), 64'd1);
    check("drop_no_valid", 64'(m_valid_o), 64'd0);
    put_beat(64'h4444_0000_0000_0001, 4'd0, 1'b0);
    check("drop_no_valid2", 64'(m_valid_o), 64'd0);
    put_beat(64'h4444_0000_0000_0002, 4'd0, 1'b1);
    check("drop_cnt_one", 64'(drop_cnt_o), 64'd1);
    check("drop_no_valid3", 64'(m_valid_o), 64'd0);
    put_beat(64'h4444_0000_0000_0003, 4'd0, 1'b1);
    check("after_drop_valid", 64'(m_valid_o), 64'(10'b0000000001));
    idle(1);

    // Back-to-back single-beat packets
    put_beat(64'h5555_0000_0000_0001, 4'd1, 1'b1);
    check("b2b_1", 64'(m_valid_o), 64'(10'b0000000010));
    put_beat(64'h5555_0000_0000_0009, 4'd9, 1'b1);
    check("b2b_9", 64'(m_valid_o), 64'(10'b1000000000));
    put_beat(64'h5555_0000_0000_0000, 4'd0, 1'b1);
    check("b2b_0", 64'(m_valid_o), 64'(10'b0000000001));
    idle(1);

    // Single-beat vector table
    for (int i = 0; i < 8; i++) begin
      put_beat(tbl[i].data, tbl[i].dest, 1'b1);
      check("tbl_valid", 64'(m_valid_o), 64'(tbl[i].exp_valid));
      check("tbl_cnt", 64'(drop_cnt_o), 64'(tbl[i].exp_cnt));
      if (tbl[i].exp_valid != '0) check("tbl_data", m_data_o, tbl[i].data);
    end
    idle(1);

    // Randomized packets with random downstream backpressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          m_ready_i = M'($urandom) | M'($urandom);
        end
      end
    join_none
    for (int p = 0; p < 150; p++) begin
      len  = $urandom_range(1, 4);
      dest = $urandom_range(0, 15);
      for (int b = 0; b < len; b++) begin
        put_beat({$urandom, $urandom}, (b == 0) ? 4'(dest) : 4'($urandom_range(0, 15)), b == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rnd_on = 1'b0;
    @(posedge clk); #2;
    m_ready_i = ALL_READY;
    drain();

    // Reset on beat 2 of a 5-beat packet; remaining beats form a new packet
    put_beat(64'h6666_0000_0000_0000, 4'd4, 1'b0);
    s_valid_i = 1'b1; s_data_i = 64'h6666_0000_0000_0001; s_dest_i = 4'd4; s_last_i = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    s_valid_i = 1'b0;
    check("mid_rst_valid", 64'(m_valid_o), 64'd0);
    check("mid_rst_cnt", 64'(drop_cnt_o), 64'd0);
    check("mid_rst_ready", 64'(s_ready_o), 64'd0);
    @(posedge clk); #1;
    check("mid_rst_ready_up", 64'(s_ready_o), 64'd1);
    for (int k = 2; k < 5; k++) begin
      put_beat(64'h6666_0000_0000_0000 + 64'(k), 4'd6, k == 4);
      check("resample_valid", 64'(m_valid_o), 64'(10'b0001000000));
    end
    drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
